// File: rtl/project_pkg.sv
// Shared types and constants for the image-decode SRAM sequencer.
package project_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [2:0] {
    S_SEQ_IDLE      = 3'd0,
    S_SEQ_UART_INIT = 3'd1,
    S_SEQ_UART_RX   = 3'd2,
    S_SEQ_M2        = 3'd3,
    S_SEQ_M1        = 3'd4,
    S_SEQ_DONE      = 3'd5
  } seq_state_type;

  localparam logic [1:0] MODE_FULL = 2'd0;
  localparam logic [1:0] MODE_M1   = 2'd1;
  localparam logic [1:0] MODE_M2   = 2'd2;
  localparam logic [1:0] MODE_NONE = 2'd3;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic               we_n;
  } sram_req_t;

endpackage

// File: rtl/decode_sequencer_if.sv
// Requester, handshake and SRAM-port bundle around the decode sequencer.
interface decode_sequencer_if;
  import project_pkg::*;

  logic               UART_RX_I;
  logic [1:0]         mode_i;
  logic [SRAM_AW-1:0] uart_addr_i, m2_addr_i, m1_addr_i, vga_addr_i;
  logic [SRAM_DW-1:0] uart_wdata_i, m2_wdata_i, m1_wdata_i;
  logic               uart_we_n_i, m2_we_n_i, m1_we_n_i;
  logic               uart_init_o, uart_enable_o;
  logic               m2_start_o, m2_done_i, m1_start_o, m1_done_i;
  logic               vga_enable_o;
  logic [SRAM_AW-1:0] sram_addr_o;
  logic [SRAM_DW-1:0] sram_wdata_o;
  logic               sram_we_n_o;
  logic [2:0]         owner_o;
  logic               timeout_err_o;

  // Environment side: requesters, milestones, VGA and SRAM controller.
  modport master (
    output UART_RX_I, mode_i,
    output uart_addr_i, uart_wdata_i, uart_we_n_i,
    output m2_addr_i, m2_wdata_i, m2_we_n_i, m2_done_i,
    output m1_addr_i, m1_wdata_i, m1_we_n_i, m1_done_i,
    output vga_addr_i,
    input  uart_init_o, uart_enable_o, m2_start_o, m1_start_o, vga_enable_o,
    input  sram_addr_o, sram_wdata_o, sram_we_n_o, owner_o, timeout_err_o
  );

  // Sequencer side.
  modport slave (
    input  UART_RX_I, mode_i,
    input  uart_addr_i, uart_wdata_i, uart_we_n_i,
    input  m2_addr_i, m2_wdata_i, m2_we_n_i, m2_done_i,
    input  m1_addr_i, m1_wdata_i, m1_we_n_i, m1_done_i,
    input  vga_addr_i,
    output uart_init_o, uart_enable_o, m2_start_o, m1_start_o, vga_enable_o,
    output sram_addr_o, sram_wdata_o, sram_we_n_o, owner_o, timeout_err_o
  );
endinterface

// File: rtl/decode_sequencer_sram_port_mux.sv
// Combinational 4-way SRAM request selector keyed on the current owner.
module sram_port_mux
  import project_pkg::*;
(
  input  seq_state_type      owner,
  input  sram_req_t          uart_req,
  input  sram_req_t          m2_req,
  input  sram_req_t          m1_req,
  input  logic [SRAM_AW-1:0] vga_addr,
  output sram_req_t          sram_req
);
  always_comb begin
    sram_req = '{addr: vga_addr, wdata: '0, we_n: 1'b1};
    case (owner)
      S_SEQ_UART_INIT,
      S_SEQ_UART_RX: sram_req = uart_req;
      S_SEQ_M2:      sram_req = m2_req;
      S_SEQ_M1:      sram_req = m1_req;
      default:       sram_req = '{addr: vga_addr, wdata: '0, we_n: 1'b1};
    endcase
  end
endmodule

// File: rtl/decode_sequencer.sv
// SRAM ownership sequencer: UART receive, then M2/M1 decode with watchdogs,
// then hand the port back to the VGA reader.
module decode_sequencer
  import project_pkg::*;
#(
  parameter logic [25:0] UART_TIMEOUT = 26'd49999999,
  parameter logic [25:0] MS_TIMEOUT   = 26'd50000000
) (
  input logic               CLOCK_50_I,
  input logic               resetn,
  decode_sequencer_if.slave bus
);
  seq_state_type state;
  logic [25:0]   timer;
  logic          vga_en, uart_init, uart_en, m1_start, m2_start, err;
  sram_req_t     sram_req;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state     <= S_SEQ_IDLE;
      timer     <= '0;
      vga_en    <= 1'b1;
      uart_init <= 1'b0;
      uart_en   <= 1'b0;
      m1_start  <= 1'b0;
      m2_start  <= 1'b0;
      err       <= 1'b0;
    end else begin
      uart_init <= 1'b0;
      m1_start  <= 1'b0;
      m2_start  <= 1'b0;
      case (state)
        S_SEQ_IDLE:
          if (!bus.UART_RX_I) begin
            state     <= S_SEQ_UART_INIT;
            uart_init <= 1'b1;
            timer     <= '0;
            vga_en    <= 1'b0;
          end
        S_SEQ_UART_INIT: begin
          uart_en <= 1'b1;
          state   <= S_SEQ_UART_RX;
        end
        // A write in the expiry cycle restarts the idle window, so the exit
        // is always a full timeout after the last write.
        S_SEQ_UART_RX:
          if (!bus.uart_we_n_i) timer <= '0;
          else if (timer == UART_TIMEOUT) begin
            uart_en <= 1'b0;
            timer   <= '0;
            case (bus.mode_i)
              MODE_FULL, MODE_M2: begin state <= S_SEQ_M2; m2_start <= 1'b1; end
              MODE_M1:            begin state <= S_SEQ_M1; m1_start <= 1'b1; end
              default:            state <= S_SEQ_DONE;
            endcase
          end else timer <= timer + 26'd1;
        // done is checked before the watchdog so a coincident done wins.
        S_SEQ_M2:
          if (bus.m2_done_i) begin
            timer <= '0;
            if (bus.mode_i == MODE_FULL) begin
              state    <= S_SEQ_M1;
              m1_start <= 1'b1;
            end else state <= S_SEQ_DONE;
          end else if (timer == MS_TIMEOUT) begin
            err   <= 1'b1;
            timer <= '0;
            state <= S_SEQ_DONE;
          end else timer <= timer + 26'd1;
        S_SEQ_M1:
          if (bus.m1_done_i) begin
            timer <= '0;
            state <= S_SEQ_DONE;
          end else if (timer == MS_TIMEOUT) begin
            err   <= 1'b1;
            timer <= '0;
            state <= S_SEQ_DONE;
          end else timer <= timer + 26'd1;
        S_SEQ_DONE: begin
          vga_en <= 1'b1;
          timer  <= '0;
          state  <= S_SEQ_IDLE;
        end
        default: state <= S_SEQ_IDLE;
      endcase
    end
  end

  sram_port_mux u_mux (
    .owner    (state),
    .uart_req ('{addr: bus.uart_addr_i, wdata: bus.uart_wdata_i, we_n: bus.uart_we_n_i}),
    .m2_req   ('{addr: bus.m2_addr_i,   wdata: bus.m2_wdata_i,   we_n: bus.m2_we_n_i}),
    .m1_req   ('{addr: bus.m1_addr_i,   wdata: bus.m1_wdata_i,   we_n: bus.m1_we_n_i}),
    .vga_addr (bus.vga_addr_i),
    .sram_req (sram_req)
  );

  assign bus.sram_addr_o   = sram_req.addr;
  assign bus.sram_wdata_o  = sram_req.wdata;
  assign bus.sram_we_n_o   = sram_req.we_n;
  assign bus.owner_o       = state;
  assign bus.vga_enable_o  = vga_en;
  assign bus.uart_init_o   = uart_init;
  assign bus.uart_enable_o = uart_en;
  assign bus.m1_start_o    = m1_start;
  assign bus.m2_start_o    = m2_start;
  assign bus.timeout_err_o = err;
endmodule

// File: tb/tb_decode_sequencer.sv
// Randomized scenario bench for decode_sequencer with a latency-rule model.
module tb_decode_sequencer;
  import project_pkg::*;

  localparam logic [25:0] UT = 26'd100;
  localparam logic [25:0] MT = 26'd500;
  localparam int UTI = 100;
  localparam int MTI = 500;

  logic CLOCK_50_I = 1'b0;
  logic resetn     = 1'b0;
  decode_sequencer_if bus();

  decode_sequencer #(.UART_TIMEOUT(UT), .MS_TIMEOUT(MT)) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .bus        (bus.slave)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  int n_chk  = 0;
  int n_fail = 0;
  int m2s_cnt, m1s_cnt;
  bit exp_err;

  always @(negedge CLOCK_50_I) begin
    if (bus.m2_start_o) m2s_cnt++;
    if (bus.m1_start_o) m1s_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  function automatic logic [34:0] sram_bus();
    return {bus.sram_addr_o, bus.sram_wdata_o, bus.sram_we_n_o};
  endfunction

  // One milestone stage: done arrives d edges after entry. The watchdog
  // fires on the (MTI+1)-th edge; a done on that same edge still wins.
  task automatic run_stage(input int own, input int d, output bit to);
    int k, exp_k;
    logic [34:0] req;
    req = {18'($urandom), 16'($urandom), 1'($urandom)};
    if (own == 3) {bus.m2_addr_i, bus.m2_wdata_i, bus.m2_we_n_i} = req;
    else          {bus.m1_addr_i, bus.m1_wdata_i, bus.m1_we_n_i} = req;
    #1;
    chk($sformatf("stage%0d_mux", own), sram_bus(), req);
    k = 0;
    while (bus.owner_o == 3'(own) && k < MTI + 20) begin
      k++;
      bus.UART_RX_I = 1'($urandom);
      if (k == d) begin
        if (own == 3) bus.m2_done_i = 1'b1;
        else          bus.m1_done_i = 1'b1;
      end
      tick();
      bus.m2_done_i = 1'b0;
      bus.m1_done_i = 1'b0;
    end
    bus.UART_RX_I = 1'b1;
    to    = (d > MTI + 1);
    exp_k = to ? MTI + 1 : d;
    chk($sformatf("stage%0d_len", own), k, exp_k);
  endtask

  task automatic run_seq(input int mode, input int nwr, input int gap, input int d2, input int d1);
    int k;
    bit to, m2_ok;
    logic [34:0] req;
    bus.mode_i     = 2'(mode);
    bus.vga_addr_i = 18'($urandom);
    m2s_cnt = 0;
    m1s_cnt = 0;
    #1;
    chk("idle_owner", bus.owner_o, 0);
    chk("idle_vga", bus.vga_enable_o, 1);
    chk("idle_mux", sram_bus(), {bus.vga_addr_i, 16'h0, 1'b1});
    bus.UART_RX_I = 1'b0;
    tick();
    bus.UART_RX_I = 1'b1;
    chk("init_owner", bus.owner_o, 1);
    chk("init_pulse", bus.uart_init_o, 1);
    chk("init_vga", bus.vga_enable_o, 0);
    bus.uart_addr_i = 18'h00010;
    #1;
    chk("init_mux", bus.sram_addr_o, 18'h00010);
    tick();
    chk("rx_owner", {bus.owner_o, bus.uart_init_o, bus.uart_enable_o}, {3'd2, 1'b0, 1'b1});
    for (int i = 0; i < nwr; i++) begin
      repeat (gap - 1) tick();
      bus.uart_we_n_i = 1'b0;
      bus.uart_addr_i = 18'($urandom);
      bus.uart_wdata_i = 16'($urandom);
      req = {bus.uart_addr_i, bus.uart_wdata_i, 1'b0};
      #1;
      chk("rx_mux", sram_bus(), req);
      tick();
      bus.uart_we_n_i = 1'b1;
    end
    k = 0;
    while (bus.owner_o == 3'd2 && k < UTI + 20) begin
      tick();
      k++;
    end
    chk("rx_exit", k, UTI + 1);
    chk("rx_next", bus.owner_o, (mode == 3) ? 5 : (mode == 1) ? 4 : 3);
    chk("rx_starts", {bus.m2_start_o, bus.m1_start_o, bus.uart_enable_o},
        {1'(mode == 0 || mode == 2), 1'(mode == 1), 1'b0});
    m2_ok = 1'b0;
    if (mode == 0 || mode == 2) begin
      run_stage(3, d2, to);
      if (to) exp_err = 1'b1;
      m2_ok = !to;
      if (mode == 0 && m2_ok) begin
        chk("m2_to_m1", {bus.owner_o, bus.m1_start_o}, {3'd4, 1'b1});
        run_stage(4, d1, to);
        if (to) exp_err = 1'b1;
      end
    end else if (mode == 1) begin
      run_stage(4, d1, to);
      if (to) exp_err = 1'b1;
    end
    chk("done_state", {bus.owner_o, bus.vga_enable_o}, {3'd5, 1'b0});
    chk("err_flag", bus.timeout_err_o, exp_err);
    tick();
    chk("back_idle", {bus.owner_o, bus.vga_enable_o}, {3'd0, 1'b1});
    chk("m2_starts", m2s_cnt, (mode == 0 || mode == 2) ? 1 : 0);
    chk("m1_starts", m1s_cnt, (mode == 1 || (mode == 0 && m2_ok)) ? 1 : 0);
    bus.m2_done_i = 1'b1;
    bus.m1_done_i = 1'b1;
    tick();
    bus.m2_done_i = 1'b0;
    bus.m1_done_i = 1'b0;
    chk("late_done", {bus.owner_o, bus.timeout_err_o, bus.m1_start_o}, {3'd0, exp_err, 1'b0});
    tick();
  endtask

  initial begin
    bus.UART_RX_I = 1'b1;
    bus.mode_i = 2'd0;
    {bus.uart_addr_i, bus.uart_wdata_i, bus.uart_we_n_i} = '1;
    {bus.m2_addr_i, bus.m2_wdata_i, bus.m2_we_n_i} = '1;
    {bus.m1_addr_i, bus.m1_wdata_i, bus.m1_we_n_i} = '1;
    bus.m2_done_i = 1'b0;
    bus.m1_done_i = 1'b0;
    bus.vga_addr_i = 18'h2abcd;
    exp_err = 1'b0;
    repeat (3) tick();
    chk("rst_outs", {bus.owner_o, bus.vga_enable_o, bus.uart_init_o, bus.uart_enable_o,
                     bus.m1_start_o, bus.m2_start_o, bus.timeout_err_o},
        {3'd0, 1'b1, 5'b0});
    chk("rst_mux", sram_bus(), {18'h2abcd, 16'h0, 1'b1});
    resetn = 1'b1;
    tick();

    run_seq(0, 3, 50, 200, 30);
    run_seq(1, 1, 10, 0, MTI + 1);
    run_seq(3, 0, 1, 0, 0);
    run_seq(2, 2, UTI, 40, 0);
    run_seq(0, 1, 1, MTI + 2, 0);
    for (int n = 0; n < 8; n++)
      run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, UTI),
              $urandom_range(1, 520), $urandom_range(1, 520));

    // Reset in the middle of M1.
    bus.mode_i = 2'd1;
    bus.UART_RX_I = 1'b0;
    tick();
    bus.UART_RX_I = 1'b1;
    for (int k = 0; k < UTI + 20 && bus.owner_o != 3'd4; k++) tick();
    chk("pre_rst_m1", bus.owner_o, 4);
    repeat (10) tick();
    resetn = 1'b0;
    exp_err = 1'b0;
    #1;
    chk("mid_rst_outs", {bus.owner_o, bus.vga_enable_o, bus.uart_init_o, bus.uart_enable_o,
                         bus.m1_start_o, bus.m2_start_o, bus.timeout_err_o},
        {3'd0, 1'b1, 5'b0});
    chk("mid_rst_mux", sram_bus(), {bus.vga_addr_i, 16'h0, 1'b1});
    tick();
    resetn = 1'b1;
    tick();
    run_seq(0, 1, 20, 5, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
